// File: rtl/alu_exec_unit.sv
// Execution ALU: single-cycle ops return next cycle; MUL is an iterative shift-add
// multiplier with a fixed WIDTH-cycle busy window and a one-cycle done pulse.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       shamt_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StMulRun = 1'b1;

  localparam logic [3:0] CtrlAnd  = 4'b0000;
  localparam logic [3:0] CtrlOr   = 4'b0001;
  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlSub  = 4'b0110;
  localparam logic [3:0] CtrlSlt  = 4'b0111;
  localparam logic [3:0] CtrlSra  = 4'b1000;
  localparam logic [3:0] CtrlSrav = 4'b1001;
  localparam logic [3:0] CtrlMul  = 4'b1011;
  localparam logic [3:0] CtrlBne  = 4'b1100;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [0:0]       state_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, product_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, done_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic [WIDTH-1:0] prod_next;

  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      CtrlAnd:  alu_res = src1_i & src2_i;
      CtrlOr:   alu_res = src1_i | src2_i;
      CtrlAdd:  alu_res = src1_i + src2_i;
      CtrlSub:  alu_res = src1_i - src2_i;
      CtrlSlt:  alu_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      CtrlSra:  alu_res = WIDTH'($signed(src2_i) >>> shamt_i);
      CtrlSrav: alu_res = WIDTH'($signed(src2_i) >>> src1_i[4:0]);
      CtrlBne:  alu_res = src1_i - src2_i;
      default:  alu_res = '0;
    endcase
    // BNE inverts the flag so branch-taken is zero_o for both BEQ and BNE.
    alu_zero = (ctrl_i == CtrlBne) ? (alu_res != '0) : (alu_res == '0);
  end

  assign prod_next = product_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      count_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (ctrl_i == CtrlMul) begin
              mcand_q   <= src1_i;
              mplier_q  <= src2_i;
              product_q <= '0;
              count_q   <= '0;
              state_q   <= StMulRun;
            end else begin
              result_q <= alu_res;
              zero_q   <= alu_zero;
              done_q   <= 1'b1;
            end
          end
        end
        StMulRun: begin
          product_q <= prod_next;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          count_q   <= count_q + 1'b1;
          if (count_q == CntLast) begin
            result_q <= prod_next;
            zero_q   <= (prod_next == '0);
            done_q   <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign busy_o   = (state_q == StMulRun);
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: single-cycle ops, branch flags, MUL handshake,
// reset abort and back-to-back issue.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'b0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result;
  logic        zero, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .ctrl_i  (ctrl),
    .src1_i  (src1),
    .src2_i  (src2),
    .shamt_i (shamt),
    .result_o(result),
    .zero_o  (zero),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then drop start.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    start = 1'b1; ctrl = c; src1 = a; src2 = b; shamt = sh;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (result !== 32'h0 || zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: result=%h zero=%b busy=%b done=%b, want 0/0/0/0",
               result, zero, busy, done);
    end
  endtask

  task automatic test_add();
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 32'h8000_0000 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL add_ovf: done=%b busy=%b result=%h zero=%b, want 1/0/80000000/0",
               done, busy, result, zero);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || result !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL add_hold: done=%b result=%h, want 0/80000000", done, result);
    end
  endtask

  task automatic test_branch();
    issue(4'b0110, 32'h1234, 32'h1234, 5'd0);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL sub_eq: done=%b result=%h zero=%b, want 1/0/1", done, result, zero);
    end
    issue(4'b1100, 32'h1234, 32'h1234, 5'd0);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h0 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL bne_eq: done=%b result=%h zero=%b, want 1/0/0", done, result, zero);
    end
    issue(4'b1100, 32'd5, 32'd3, 5'd0);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'd2 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL bne_ne: done=%b result=%h zero=%b, want 1/2/1", done, result, zero);
    end
  endtask

  task automatic test_logic_shift();
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0);
    n_cmp++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL slt_unsigned: result=%h zero=%b, want 0/1", result, zero);
    end
    issue(4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd0);
    n_cmp++;
    if (result !== 32'h1 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL slt_true: result=%h zero=%b, want 1/0", result, zero);
    end
    issue(4'b1000, 32'h0, 32'h8000_0000, 5'd4);
    n_cmp++;
    if (result !== 32'hF800_0000) begin
      n_bad++;
      $display("FAIL sra: result=%h, want f8000000", result);
    end
    issue(4'b1001, 32'h0000_0021, 32'hF000_0000, 5'd7);
    n_cmp++;
    if (result !== 32'hF800_0000) begin
      n_bad++;
      $display("FAIL srav: result=%h, want f8000000", result);
    end
    issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    n_cmp++;
    if (result !== 32'h00F0_1200) begin
      n_bad++;
      $display("FAIL and: result=%h, want 00f01200", result);
    end
    issue(4'b0001, 32'hF000_000F, 32'h0F00_00F0, 5'd0);
    n_cmp++;
    if (result !== 32'hFF00_00FF) begin
      n_bad++;
      $display("FAIL or: result=%h, want ff0000ff", result);
    end
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1, 5'd3);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal: done=%b result=%h zero=%b, want 1/0/1", done, result, zero);
    end
  endtask

  task automatic test_mul();
    logic [31:0] a [2] = '{32'h0000_FFFF, 32'hFFFF_FFFD};
    logic [31:0] b [2] = '{32'h0001_0001, 32'h0000_0007};
    logic [31:0] e [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFEB};
    for (int t = 0; t < 2; t++) begin
      int busy_cnt;
      logic early_done;
      logic [31:0] held;
      held = result;
      busy_cnt = 0;
      early_done = 1'b0;
      issue(4'b1011, a[t], b[t], 5'd0);
      // 32 cycles of busy; stray ADD requests must be ignored.
      for (int i = 0; i < 32; i++) begin
        if (busy === 1'b1) busy_cnt++;
        if (done !== 1'b0 || result !== held) early_done = 1'b1;
        start = (i % 5 == 2);
        ctrl = 4'b0010; src1 = 32'h1; src2 = 32'h1;
        tick();
      end
      start = 1'b0;
      n_cmp++;
      if (busy_cnt != 32 || early_done) begin
        n_bad++;
        $display("FAIL mul_busy[%0d]: busy_cycles=%0d early=%b, want 32/0",
                 t, busy_cnt, early_done);
      end
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== e[t] || zero !== 1'b0) begin
        n_bad++;
        $display("FAIL mul_done[%0d]: done=%b busy=%b result=%h zero=%b, want 1/0/%h/0",
                 t, done, busy, result, zero, e[t]);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== e[t]) begin
        n_bad++;
        $display("FAIL mul_after[%0d]: done=%b busy=%b result=%h, want 0/0/%h",
                 t, done, busy, result, e[t]);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    issue(4'b1011, 32'd123, 32'd456, 5'd0);
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_mul_busy: busy=%b, want 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL mul_abort: busy=%b done=%b result=%h zero=%b, want 0/0/0/0",
               busy, done, result, zero);
    end
    // No late done should surface from the aborted multiply.
    for (int i = 0; i < 30; i++) begin
      if (done !== 1'b0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mul_abort_done: done=%b at cycle %0d, want 0", done, i);
        break;
      end
      tick();
    end
    issue(4'b0010, 32'd2, 32'd2, 5'd0);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'd4 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL add_after_rst: done=%b result=%h zero=%b, want 1/4/0",
               done, result, zero);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    issue(4'b1011, 32'd6, 32'd7, 5'd0);
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (guard != 32 || result !== 32'd42) begin
      n_bad++;
      $display("FAIL b2b_mul: wait=%0d result=%h, want 32/0000002a", guard, result);
    end
    // Issue ADD in the done cycle; it must be accepted.
    issue(4'b0010, 32'd10, 32'd20, 5'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 32'd30) begin
      n_bad++;
      $display("FAIL b2b_add: done=%b busy=%b result=%h, want 1/0/0000001e",
               done, busy, result);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_branch();
    test_logic_shift();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU control code generated by the pipeline's ALU control decoder.
- Performs the selected operation on two operands and returns a registered result plus a zero/branch flag.
- Single-cycle ops complete one cycle after start. MUL runs as an iterative shift-add multiplier over WIDTH cycles, with busy/done handshake so the hazard/stall logic can freeze the pipeline.

Parameters:
WIDTH, 32, operand/result width in bits (shift-amount width fixed at 5; WIDTH must be 32)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  request: sample ctrl_i/src1_i/src2_i/shamt_i this cycle
ctrl_i  input  4  ALU control code
src1_i  input  WIDTH  operand 1 (rs)
src2_i  input  WIDTH  operand 2 (rt / immediate)
shamt_i  input  5  shift amount for SRA
result_o  output  WIDTH  registered result, held until next done_o
zero_o  output  1  registered branch flag, held with result_o
busy_o  output  1  high while multiply in progress; start_i ignored
done_o  output  1  one-cycle pulse: result_o/zero_o updated this cycle

Behaviour:
- Reset (rst_i=1 at edge): result_o=0, zero_o=0, busy_o=0, done_o=0, FSM->IDLE, counter=0, internal product/multiplicand/multiplier regs=0. Reset mid-multiply aborts it; no done_o is produced.
- FSM states: IDLE, MUL_RUN.
  - IDLE + start_i=1 + ctrl_i!=1011: compute combinationally, register at the same edge. done_o=1 next cycle; busy_o stays 0. Latency 1.
  - IDLE + start_i=1 + ctrl_i=1011: latch multiplicand=src1_i, multiplier=src2_i, product=0, counter=0. Go to MUL_RUN; busy_o=1 from next cycle.
  - MUL_RUN, each cycle:
    - if multiplier[0], product += multiplicand (mod 2^WIDTH);
    - multiplicand <<= 1; multiplier >>= 1; counter++.
    - On the edge where counter reaches WIDTH-1: result_o=final product, zero_o=(product==0), done_o=1, busy_o=0, FSM->IDLE.
  - Timing: start sampled at edge k gives busy_o high during cycles k+1..k+WIDTH, and done_o/result visible in cycle k+WIDTH+1. The multiplier never early-terminates, so latency is fixed.
- start_i while busy_o=1: ignored, no effect on in-flight multiply.
- start_i may be asserted in the same cycle done_o=1 (IDLE); it is accepted.
- done_o is 0 in every cycle not listed above.
- Operations (WIDTH-bit, two's complement, all wrap mod 2^WIDTH, no overflow flag):
  - 0000 AND: src1 & src2.
  - 0001 OR: src1 | src2.
  - 0010 ADD: src1 + src2.
  - 0110 SUB: src1 - src2.
  - 0111 SLT: 1 if src1 < src2 as unsigned, else 0. Single code serves SLT and SLTIU; unsigned compare is the decided semantic.
  - 1000 SRA: src2 >>> shamt_i (arithmetic).
  - 1001 SRAV: src2 >>> src1[4:0].
  - 1011 MUL: low WIDTH bits of src1*src2. Identical for signed/unsigned.
  - 1100 BNE: result = src1 - src2; zero_o = (result != 0).
  - Any other code: result = 0.
- zero_o = (result == 0) for all codes except 1100, which uses the inverted sense above. With this, branch-taken = zero_o for both BEQ(0110) and BNE(1100).
- result_o/zero_o change only on reset or on an edge producing done_o.

Test Plan:
- Reset then ADD: rst_i 1 cycle; start ctrl=0010, src1=0x7FFFFFFF, src2=1 -> next cycle done_o=1, result_o=0x80000000, zero_o=0, busy_o never 1.
- Branch flags: SUB src1=src2=0x1234 -> result 0, zero_o=1. BNE same operands -> result 0, zero_o=0. BNE 5 vs 3 -> result 2, zero_o=1.
- SLT/shifts:
  - SLT 0xFFFFFFFF vs 1 -> result 0 (unsigned).
  - SRA src2=0x80000000, shamt=4 -> 0xF8000000.
  - SRAV src1=0x00000021, src2=0xF0000000 -> shift 1 -> 0xF8000000.
- MUL latency/handshake: start 1011 with 0x0000FFFF, 0x00010001 at edge k. Expect busy_o high for exactly 32 cycles, start_i pulses with ctrl=0010 during busy ignored, then done_o one cycle at k+33 with result 0xFFFFFFFF. Also -3*7 -> 0xFFFFFFEB.
- Reset mid-MUL: start MUL, assert rst_i after 10 busy cycles -> next cycle busy_o=0, done_o=0, result_o=0. A following ADD 2+2 returns 4 after 1 cycle.
- Back-to-back and illegal code: start ADD in the cycle MUL's done_o=1 -> accepted, done_o next cycle with ADD result. ctrl=1111 -> result 0, zero_o=1.
